// File: rtl/sdrc_app_arbiter.sv
// Purpose : round-robin share of the single SDRAM controller application port among NREQ masters.
// Latency : m_req -> app_req 1 cycle; ownership held through the burst's last beat, then >=1 IDLE cycle.
// Backpres: app_req held until app_req_ack; no grant while app_busy_n=0; data strobes routed to owner only.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   m_req/m_req_addr/m_req_len/m_req_wr_n/m_req_ack    per-requester request channel (packed slices)
//   m_wr_data/m_wr_en_n/m_wr_next/m_last_wr           per-requester write-data channel
//   m_rd_valid/m_last_rd/m_rd_data                    per-requester read-data channel (data broadcast)
//   app_*                       controller-side application port
//   arb_owner/arb_busy/arb_err  status: current/last owner, not idle, watchdog abort pulse
//
// Optional feature: define SDRC_ARB_WDOG_EN to abort a data phase that waits WDOG_CYC cycles
// without its last beat (arb_err pulses, arbiter returns to IDLE). Undefined: arb_err is tied 0.

module sdrc_app_arbiter #(
  parameter  int NREQ     = 2,
  parameter  int APP_AW   = 26,
  parameter  int APP_DW   = 32,
  parameter  int APP_BW   = 4,
  parameter  int BL       = 9,
  parameter  int WDOG_CYC = 1024,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NREQ-1:0]          m_req,
  input  logic [NREQ*APP_AW-1:0]   m_req_addr,
  input  logic [NREQ*BL-1:0]       m_req_len,
  input  logic [NREQ-1:0]          m_req_wr_n,
  output logic [NREQ-1:0]          m_req_ack,
  input  logic [NREQ*APP_DW-1:0]   m_wr_data,
  input  logic [NREQ*APP_BW-1:0]   m_wr_en_n,
  output logic [NREQ-1:0]          m_wr_next,
  output logic [NREQ-1:0]          m_rd_valid,
  output logic [NREQ-1:0]          m_last_wr,
  output logic [NREQ-1:0]          m_last_rd,
  output logic [APP_DW-1:0]        m_rd_data,
  output logic                     app_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [BL-1:0]            app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  input  logic                     app_busy_n,
  output logic [APP_DW-1:0]        app_wr_data,
  output logic [APP_BW-1:0]        app_wr_en_n,
  input  logic                     app_wr_next_req,
  input  logic                     app_rd_valid,
  input  logic                     app_last_wr,
  input  logic                     app_last_rd,
  input  logic [APP_DW-1:0]        app_rd_data,
  output logic [OW-1:0]            arb_owner,
  output logic                     arb_busy,
  output logic                     arb_err
);

  // Elaboration-time parameter sanity check.
  if (NREQ < 2 || NREQ > 8 || WDOG_CYC < 2 || WDOG_CYC > 65536) begin : g_bad_param
    $error("sdrc_app_arbiter: NREQ must be 2..8 and WDOG_CYC 2..65536");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;     // highest-priority requester for the next grant
  logic [OW-1:0] owner;

  // Unpacked views of the packed per-requester buses.
  logic [APP_AW-1:0] addr_arr  [NREQ];
  logic [BL-1:0]     len_arr   [NREQ];
  logic [APP_DW-1:0] wdata_arr [NREQ];
  logic [APP_BW-1:0] wen_arr   [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = m_req_addr[i*APP_AW +: APP_AW];
    assign len_arr[i]   = m_req_len[i*BL +: BL];
    assign wdata_arr[i] = m_wr_data[i*APP_DW +: APP_DW];
    assign wen_arr[i]   = m_wr_en_n[i*APP_BW +: APP_BW];
  end

  // (a + b) mod NREQ for operands already below NREQ.
  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [OW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (OW+1)'(NREQ)) s = s - (OW+1)'(NREQ);
    return s[OW-1:0];
  endfunction

  // Round-robin pick: scan from the farthest offset down so the nearest
  // asserted requester at or after ptr is the one left standing.
  logic          gnt_vld;
  logic [OW-1:0] gnt_idx;
  logic [OW-1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = wrap_add(ptr, OW'(k));
      if (m_req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

`ifdef SDRC_ARB_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);
  logic [15:0] wdog_cnt;
`else
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      app_req      <= 1'b0;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b0;
`ifdef SDRC_ARB_WDOG_EN
      wdog_cnt     <= '0;
      arb_err      <= 1'b0;
`endif
    end else begin
`ifdef SDRC_ARB_WDOG_EN
      arb_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (gnt_vld && app_busy_n) begin
            owner        <= gnt_idx;
            app_req_addr <= addr_arr[gnt_idx];
            app_req_len  <= len_arr[gnt_idx];
            app_req_wr_n <= m_req_wr_n[gnt_idx];
            app_req      <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          // Request fields stay frozen; a dropped m_req is not a cancel.
          if (app_req_ack) begin
            app_req <= 1'b0;
            ptr     <= wrap_add(owner, OW'(1));
            state   <= app_req_wr_n ? RD_DATA : WR_DATA;
`ifdef SDRC_ARB_WDOG_EN
            wdog_cnt <= '0;
`endif
          end
        end
        WR_DATA: begin
          if (app_last_wr) begin
            state <= IDLE;
`ifdef SDRC_ARB_WDOG_EN
          end else if (wdog_cnt == WDOG_LAST) begin
            arb_err <= 1'b1;
            state   <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
`endif
          end
        end
        RD_DATA: begin
          if (app_last_rd) begin
            state <= IDLE;
`ifdef SDRC_ARB_WDOG_EN
          end else if (wdog_cnt == WDOG_LAST) begin
            arb_err <= 1'b1;
            state   <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake routing: only the owner sees strobes, and only in the matching phase.
  always_comb begin
    m_req_ack   = '0;
    m_wr_next   = '0;
    m_rd_valid  = '0;
    m_last_wr   = '0;
    m_last_rd   = '0;
    app_wr_data = '0;
    app_wr_en_n = '1;
    case (state)
      REQ: begin
        m_req_ack[owner] = app_req_ack;
      end
      WR_DATA: begin
        m_wr_next[owner] = app_wr_next_req;
        m_last_wr[owner] = app_last_wr;
        app_wr_data      = wdata_arr[owner];
        app_wr_en_n      = wen_arr[owner];
      end
      RD_DATA: begin
        m_rd_valid[owner] = app_rd_valid;
        m_last_rd[owner]  = app_last_rd;
      end
      default: ;
    endcase
  end

  assign m_rd_data = app_rd_data;
  assign arb_owner = owner;
  assign arb_busy  = (state != IDLE);

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
module tb_sdrc_app_arbiter;
  localparam int NREQ = 3, AW = 26, DW = 32, BW = 4, BL = 9, WDOG = 16, OW = 2;

  logic                 clk = 1'b0;
  logic                 wb_rst_i;
  logic [NREQ-1:0]      m_req, m_req_wr_n;
  logic [NREQ*AW-1:0]   m_req_addr;
  logic [NREQ*BL-1:0]   m_req_len;
  logic [NREQ*DW-1:0]   m_wr_data;
  logic [NREQ*BW-1:0]   m_wr_en_n;
  logic [NREQ-1:0]      m_req_ack, m_wr_next, m_rd_valid, m_last_wr, m_last_rd;
  logic [DW-1:0]        m_rd_data;
  logic                 app_req, app_req_wr_n, app_req_ack, app_busy_n;
  logic [AW-1:0]        app_req_addr;
  logic [BL-1:0]        app_req_len;
  logic [DW-1:0]        app_wr_data, app_rd_data;
  logic [BW-1:0]        app_wr_en_n;
  logic                 app_wr_next_req, app_rd_valid, app_last_wr, app_last_rd;
  logic [OW-1:0]        arb_owner;
  logic                 arb_busy, arb_err;

  always #5 clk = ~clk;

  sdrc_app_arbiter #(.NREQ(NREQ), .APP_AW(AW), .APP_DW(DW), .APP_BW(BW), .BL(BL), .WDOG_CYC(WDOG)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .m_req(m_req), .m_req_addr(m_req_addr), .m_req_len(m_req_len), .m_req_wr_n(m_req_wr_n),
    .m_req_ack(m_req_ack), .m_wr_data(m_wr_data), .m_wr_en_n(m_wr_en_n), .m_wr_next(m_wr_next),
    .m_rd_valid(m_rd_valid), .m_last_wr(m_last_wr), .m_last_rd(m_last_rd), .m_rd_data(m_rd_data),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len), .app_req_wr_n(app_req_wr_n),
    .app_req_ack(app_req_ack), .app_busy_n(app_busy_n), .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next_req(app_wr_next_req), .app_rd_valid(app_rd_valid), .app_last_wr(app_last_wr),
    .app_last_rd(app_last_rd), .app_rd_data(app_rd_data),
    .arb_owner(arb_owner), .arb_busy(arb_busy), .arb_err(arb_err)
  );

  int checks = 0, errors = 0;

  // Reference model: who owns the port, which phase the transaction is in,
  // the captured request and the rotation start point.
  int            m_phase;    // 0 idle, 1 requesting, 2 writing, 3 reading
  int            m_own, m_ptr, m_elapsed;
  logic [AW-1:0] m_addr;
  logic [BL-1:0] m_len;
  logic          m_wrn, m_err;

  int wn_cnt [NREQ];
  int rv_cnt [NREQ];
  int dual_ack;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_own = 0; m_ptr = 0; m_elapsed = 0;
    m_addr = '0; m_len = '0; m_wrn = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_all();
    logic [NREQ-1:0] e_ack, e_wn, e_rv, e_lw, e_lr;
    logic [DW-1:0]   e_wd;
    logic [BW-1:0]   e_en;
    e_ack = '0; e_wn = '0; e_rv = '0; e_lw = '0; e_lr = '0; e_wd = '0; e_en = '1;
    if (m_phase == 1) e_ack[m_own] = app_req_ack;
    if (m_phase == 2) begin
      e_wn[m_own] = app_wr_next_req;
      e_lw[m_own] = app_last_wr;
      e_wd = m_wr_data[m_own*DW +: DW];
      e_en = m_wr_en_n[m_own*BW +: BW];
    end
    if (m_phase == 3) begin
      e_rv[m_own] = app_rd_valid;
      e_lr[m_own] = app_last_rd;
    end
    chk("app_req",      64'(app_req),      64'(m_phase == 1));
    chk("app_req_addr", 64'(app_req_addr), 64'(m_addr));
    chk("app_req_len",  64'(app_req_len),  64'(m_len));
    chk("app_req_wr_n", 64'(app_req_wr_n), 64'(m_wrn));
    chk("arb_owner",    64'(arb_owner),    64'(m_own));
    chk("arb_busy",     64'(arb_busy),     64'(m_phase != 0));
    chk("arb_err",      64'(arb_err),      64'(m_err));
    chk("m_req_ack",    64'(m_req_ack),    64'(e_ack));
    chk("m_wr_next",    64'(m_wr_next),    64'(e_wn));
    chk("m_rd_valid",   64'(m_rd_valid),   64'(e_rv));
    chk("m_last_wr",    64'(m_last_wr),    64'(e_lw));
    chk("m_last_rd",    64'(m_last_rd),    64'(e_lr));
    chk("app_wr_data",  64'(app_wr_data),  64'(e_wd));
    chk("app_wr_en_n",  64'(app_wr_en_n),  64'(e_en));
    chk("m_rd_data",    64'(m_rd_data),    64'(app_rd_data));
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic nerr;
    nerr = 1'b0;
    if (wb_rst_i) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (app_busy_n && (m_req != '0)) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (m_req[c]) begin m_own = c; break; end
        end
        m_addr  = m_req_addr[m_own*AW +: AW];
        m_len   = m_req_len[m_own*BL +: BL];
        m_wrn   = m_req_wr_n[m_own];
        m_phase = 1;
      end
      1: if (app_req_ack) begin
        m_ptr = (m_own + 1) % NREQ;
        m_phase = m_wrn ? 3 : 2;
        m_elapsed = 0;
      end
      default: begin
        if ((m_phase == 2 && app_last_wr) || (m_phase == 3 && app_last_rd)) m_phase = 0;
`ifdef SDRC_ARB_WDOG_EN
        else if (m_elapsed == WDOG - 1) begin m_phase = 0; nerr = 1'b1; end
        else m_elapsed++;
`endif
      end
    endcase
    m_err = nerr;
  endtask

  // One clock cycle: check everything against the model, log strobes, advance.
  task automatic cyc();
    #1;
    check_all();
    for (int i = 0; i < NREQ; i++) begin
      if (m_wr_next[i])  wn_cnt[i]++;
      if (m_rd_valid[i]) rv_cnt[i]++;
    end
    if ($countones(m_req_ack) > 1) dual_ack++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req = '0; app_req_ack = 1'b0; app_busy_n = 1'b1;
    app_wr_next_req = 1'b0; app_rd_valid = 1'b0; app_last_wr = 1'b0; app_last_rd = 1'b0;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NREQ; i++) begin wn_cnt[i] = 0; rv_cnt[i] = 0; end
    dual_ack = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_req = '0; app_req_ack = 1'b1; app_last_wr = 1'b1; app_last_rd = 1'b1;
    while (arb_busy && n < 10) begin cyc(); n++; end
    chk("drain_idle", 64'(arb_busy), 64'(0));
    idle_inputs();
  endtask

  task automatic set_req(input int i, input logic wrn, input logic [BL-1:0] len, input logic [AW-1:0] addr);
    m_req_wr_n[i] = wrn;
    m_req_len[i*BL +: BL] = len;
    m_req_addr[i*AW +: AW] = addr;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, b;
    logic [DW-1:0] d;

    wb_rst_i = 1'b1;
    idle_inputs();
    m_req_wr_n = '0; m_req_addr = '0; m_req_len = '0;
    m_wr_data = '0; m_wr_en_n = '1; app_rd_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_wr_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
      m_wr_en_n[i*BW +: BW] = 4'(i + 1);
    end
    model_reset();
    clr_cnt();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_app_req",   64'(app_req),     64'(0));
    chk("rst_owner",     64'(arb_owner),   64'(0));
    chk("rst_busy",      64'(arb_busy),    64'(0));
    chk("rst_err",       64'(arb_err),     64'(0));
    chk("rst_wr_en_n",   64'(app_wr_en_n), 64'(4'hF));
    chk("rst_wr_data",   64'(app_wr_data), 64'(0));
    cyc();
    wb_rst_i = 1'b0;

    // 1: single write from requester 1
    set_req(1, 1'b0, 9'd4, 26'h0001000);
    m_req = 3'b010;
    cyc();
    chk("t1_app_req", 64'(app_req),      64'(1));
    chk("t1_addr",    64'(app_req_addr), 64'(26'h0001000));
    chk("t1_len",     64'(app_req_len),  64'(4));
    chk("t1_wrn",     64'(app_req_wr_n), 64'(0));
    chk("t1_owner",   64'(arb_owner),    64'(1));
    app_req_ack = 1'b1;
    #1 chk("t1_ack", 64'(m_req_ack), 64'(3'b010));
    cyc();
    app_req_ack = 1'b0; m_req = '0;
    clr_cnt();
    for (int k = 0; k < 4; k++) begin
      app_wr_next_req = 1'b1;
      app_last_wr = (k == 3);
      #1;
      chk("t1_wdata", 64'(app_wr_data), 64'(32'hA5A5_0001));
      chk("t1_wen",   64'(app_wr_en_n), 64'(4'h2));
      cyc();
    end
    idle_inputs();
    chk("t1_wn1",  64'(wn_cnt[1]), 64'(4));
    chk("t1_wn0",  64'(wn_cnt[0]), 64'(0));
    chk("t1_idle", 64'(arb_busy),  64'(0));

    // 2: both requesters hold m_req, len-1 writes rotate 0,1,0,1
    set_req(0, 1'b0, 9'd1, 26'h0000100);
    set_req(1, 1'b0, 9'd1, 26'h0000200);
    m_req = 3'b011;
    clr_cnt();
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!app_req && n < 8) begin cyc(); n++; end
      chk("t2_req_seen", 64'(app_req), 64'(1));
      chk("t2_order", 64'(arb_owner), 64'(g % 2));
      app_req_ack = 1'b1; cyc(); app_req_ack = 1'b0;
      app_wr_next_req = 1'b1; app_last_wr = 1'b1; cyc();
      app_wr_next_req = 1'b0; app_last_wr = 1'b0;
    end
    m_req = '0;
    chk("t2_dual_ack", 64'(dual_ack), 64'(0));

    // 3: requester 0 reads len 8 while requester 1 waits
    set_req(0, 1'b1, 9'd8, 26'h0ABCDE0);
    m_req = 3'b011;
    cyc();
    chk("t3_owner", 64'(arb_owner), 64'(0));
    chk("t3_wrn",   64'(app_req_wr_n), 64'(1));
    app_req_ack = 1'b1; cyc(); app_req_ack = 1'b0;
    m_req = 3'b010;
    clr_cnt();
    b = 0; n = 0;
    while (b < 8 && n < 40) begin
      d = $urandom;
      app_rd_data = d;
      app_rd_valid = 1'($urandom_range(0, 1));
      app_last_rd = app_rd_valid && (b == 7);
      #1;
      chk("t3_rd_data", 64'(m_rd_data), 64'(d));
      chk("t3_no_ack",  64'(m_req_ack), 64'(0));
      if (app_rd_valid) b++;
      cyc();
      n++;
    end
    app_rd_valid = 1'b0; app_last_rd = 1'b0;
    chk("t3_rv0",  64'(rv_cnt[0]), 64'(8));
    chk("t3_rv1",  64'(rv_cnt[1]), 64'(0));
    chk("t3_idle", 64'(arb_busy),  64'(0));
    cyc();
    chk("t3_owner1", 64'(arb_owner), 64'(1));
    app_req_ack = 1'b1;
    #1 chk("t3_ack1", 64'(m_req_ack), 64'(3'b010));
    cyc();
    drain();

    // 4: controller busy blocks the grant
    set_req(0, 1'b0, 9'd2, 26'h0000040);
    m_req = 3'b001; app_busy_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t4_blocked", 64'(app_req), 64'(0));
    end
    app_busy_n = 1'b1;
    cyc();
    chk("t4_grant", 64'(app_req), 64'(1));
    drain();

    // 5: reset during the 2nd beat of a write by requester 1
    set_req(1, 1'b0, 9'd4, 26'h0002000);
    m_req = 3'b010;
    cyc();
    chk("t5_owner", 64'(arb_owner), 64'(1));
    app_req_ack = 1'b1; cyc(); app_req_ack = 1'b0; m_req = '0;
    app_wr_next_req = 1'b1; cyc();
    wb_rst_i = 1'b1; cyc();
    wb_rst_i = 1'b0; app_last_wr = 1'b1;
    #1;
    chk("t5_app_req", 64'(app_req),      64'(0));
    chk("t5_addr",    64'(app_req_addr), 64'(0));
    chk("t5_len",     64'(app_req_len),  64'(0));
    chk("t5_owner0",  64'(arb_owner),    64'(0));
    chk("t5_busy",    64'(arb_busy),     64'(0));
    chk("t5_wen",     64'(app_wr_en_n),  64'(4'hF));
    chk("t5_wnext",   64'(m_wr_next),    64'(0));
    idle_inputs();
    set_req(0, 1'b0, 9'd1, 26'h0000010);
    m_req = 3'b011;
    cyc();
    chk("t5_first0", 64'(arb_owner), 64'(0));
    drain();

    // 6: write burst whose last beat never arrives
    set_req(0, 1'b0, 9'd4, 26'h0000080);
    m_req = 3'b001;
    cyc();
    app_req_ack = 1'b1; cyc(); app_req_ack = 1'b0; m_req = '0;
    app_wr_next_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
`ifdef SDRC_ARB_WDOG_EN
      chk("t6_err",  64'(arb_err),  64'(k == 16));
      chk("t6_busy", 64'(arb_busy), 64'(k < 16));
`else
      chk("t6_err",  64'(arb_err),  64'(0));
      chk("t6_busy", 64'(arb_busy), 64'(1));
`endif
    end
    app_wr_next_req = 1'b0;
    drain();

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      m_req = 3'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), 9'($urandom), 26'($urandom));
        m_wr_data[i*DW +: DW] = $urandom;
        m_wr_en_n[i*BW +: BW] = 4'($urandom);
      end
      app_busy_n      = ($urandom_range(0, 9) != 0);
      app_req_ack     = 1'($urandom_range(0, 1));
      app_wr_next_req = 1'($urandom_range(0, 1));
      app_rd_valid    = 1'($urandom_range(0, 1));
      app_last_wr     = ($urandom_range(0, 4) == 0);
      app_last_rd     = ($urandom_range(0, 4) == 0);
      app_rd_data     = $urandom;
      wb_rst_i        = ($urandom_range(0, 199) == 0);
      cyc();
    end
    wb_rst_i = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdrc_app_arbiter.md
Name: sdrc_app_arbiter

Overview:
Round-robin arbiter that shares the single SDRAM controller application port (app_req/app_req_ack/app_wr_next_req/app_rd_valid) between NREQ requesters.
- Grants one requester at a time and registers its address, length and direction onto the controller request.
- Routes the write-data and read-data handshakes to the owner only.
- Holds ownership until the burst's last beat.
- Sits between the Wishbone/app-side masters and the SDRAM controller core.

Parameters:
NREQ, 2, number of requesters (2..8)
APP_AW, 26, application address width
APP_DW, 32, application data width
APP_BW, 4, byte-enable width (APP_DW/8)
BL, 9, burst length width
WDOG_CYC, 1024, data-phase watchdog limit in cycles (used only with SDRC_ARB_WDOG_EN)

Ports:
wb_clk_i  in  1  single clock; all logic on rising edge
wb_rst_i  in  1  synchronous reset, active-high
m_req  in  NREQ  per-requester request
m_req_addr  in  NREQ*APP_AW  packed request addresses (requester i at [i*APP_AW +: APP_AW])
m_req_len  in  NREQ*BL  packed burst lengths
m_req_wr_n  in  NREQ  0 = write, 1 = read
m_req_ack  out  NREQ  request accepted
m_wr_data  in  NREQ*APP_DW  packed write data
m_wr_en_n  in  NREQ*APP_BW  packed active-low byte enables
m_wr_next  out  NREQ  write beat consumed
m_rd_valid  out  NREQ  read beat valid
m_last_wr  out  NREQ  last write beat
m_last_rd  out  NREQ  last read beat
m_rd_data  out  APP_DW  read data, broadcast to all requesters
app_req  out  1  request to controller
app_req_addr  out  APP_AW  registered owner address
app_req_len  out  BL  registered owner length
app_req_wr_n  out  1  registered owner direction
app_req_ack  in  1  controller accepted request
app_busy_n  in  1  0 = controller busy
app_wr_data  out  APP_DW  owner write data
app_wr_en_n  out  APP_BW  owner byte enables
app_wr_next_req  in  1  controller consumes write beat
app_rd_valid  in  1  controller read beat valid
app_last_wr  in  1  last write beat
app_last_rd  in  1  last read beat
app_rd_data  in  APP_DW  controller read data
arb_owner  out  max(1,$clog2(NREQ))  current/last owner index
arb_busy  out  1  state != IDLE
arb_err  out  1  watchdog abort pulse

Behaviour:
- Reset values (synchronous, wb_rst_i=1):
  - State = IDLE.
  - app_req, app_req_addr, app_req_len, app_req_wr_n, arb_owner, arb_busy and arb_err = 0.
  - app_wr_en_n = all ones; app_wr_data = 0.
  - RR pointer = 0, so requester 0 has highest priority.
  - Reset mid-burst abandons the burst immediately.
- State machine: IDLE, REQ, WR_DATA, RD_DATA.
- IDLE:
  - If any m_req and app_busy_n=1, select the first asserted index at or after the pointer, wrapping modulo NREQ.
  - Capture its addr/len/wr_n and set arb_owner.
  - Next cycle: app_req=1, state REQ. Latency from m_req to app_req is 1 cycle.
  - If app_busy_n=0, no grant is made.
- REQ:
  - app_req is held high until app_req_ack=1.
  - m_req_ack[owner] = app_req_ack, combinational; all other m_req_ack bits are 0.
  - On ack: app_req=0 next cycle; pointer = owner+1 (mod NREQ); state = WR_DATA if wr_n=0, else RD_DATA.
  - Captured fields are frozen. Deassertion of m_req before ack is ignored; the request completes.
- WR_DATA:
  - app_wr_data/app_wr_en_n = owner's slice (combinational mux).
  - m_wr_next[owner] = app_wr_next_req; m_last_wr[owner] = app_last_wr.
  - app_last_wr=1 -> IDLE next cycle.
- RD_DATA:
  - m_rd_valid[owner] = app_rd_valid; m_last_rd[owner] = app_last_rd.
  - app_last_rd=1 -> IDLE next cycle.
- Outside their phase, m_wr_next, m_rd_valid and the m_last bits are 0; app_wr_en_n = all ones and app_wr_data = 0.
- m_rd_data = app_rd_data at all times.
- Regrant requires at least one IDLE cycle, so back-to-back bursts have 1 cycle of overhead.
- A last_wr/last_rd strobe seen outside the matching phase is ignored.

Optional Feature:
SDRC_ARB_WDOG_EN:
- Defined:
  - A 16-bit counter clears on entry to WR_DATA/RD_DATA and increments each cycle in those states.
  - On reaching WDOG_CYC-1 without the last beat: arb_err=1 for one cycle and state -> IDLE.
  - The pointer still advances past the aborted owner.
- Undefined: no counter; arb_err tied 0; the arbiter waits indefinitely for the last beat.

Test Plan:
1. Reset, then m_req[1]=1, write, addr 0x0001000, len 4 -> app_req=1 the next cycle with addr 0x0001000, len 4, wr_n 0. m_req_ack[1] only. Four app_wr_next_req pulses reach m_wr_next[1] only. app_wr_data equals m1's data. IDLE one cycle after app_last_wr.
2. m_req=2'b11 held continuously, all writes of len 1 -> grant order 0,1,0,1. m_req_ack never asserted for both bits in the same cycle.
3. Requester 0 reads len 8 while m_req[1] is asserted -> m_rd_valid[0] pulses 8 times with app_rd_data on m_rd_data. m_rd_valid[1]=0 throughout. m_req_ack[1] only after IDLE following app_last_rd.
4. app_busy_n=0 for 10 cycles with m_req[0]=1 -> app_req stays 0. app_req=1 one cycle after app_busy_n rises.
5. wb_rst_i pulsed during the 2nd beat of a len-4 write by requester 1 -> next cycle all outputs at reset values. A subsequent m_req=2'b11 grants requester 0 first.
6. With SDRC_ARB_WDOG_EN, WDOG_CYC=16, app_last_wr suppressed -> arb_err pulses 16 cycles after entering WR_DATA, and the arbiter returns to IDLE. Without the macro, the arbiter stays in WR_DATA and arb_err=0.
